turing_machine_gen: RTL and testbench
=====================================

# turing_machine_gen

Parametrised single-tape binary Turing machine for the tiny-tapeout demo designs. It is generalised in state count, tape length and display window, and adds a free-run mode, a step counter and tape-boundary error detection. The user programs it from switches and buttons:

1. Transition table entries are strobed in.
2. The initial tape is strobed in.
3. The machine runs, either one step per button press or one step per clock.

The display window follows the head.

## Interface

Parameters:

- `STATE_BITS`, default 2: state encoding width. There are 2^STATE_BITS states, and the all-ones state is HALT.
- `TAPE_LEN`, default 64: number of tape cells, indexed 0..TAPE_LEN-1.
- `WIN`, default 5: cells shown on each side of the head.
- `CNT_BITS`, default 16: step counter width.

Ports:

- `clock` input, 1 bit: the single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset. It clears all state, the table and the tape.
- `in_data` input, STATE_BITS+2 bits: entry word, encoded as {next_state, dir, write}. dir=1 means right; tape load uses bit 0 only.
- `next` input, 1 bit: button, level input. Only its rising edge acts.
- `done` input, 1 bit: button, level input. Its rising edge ends tape load.
- `mode` input, 1 bit: 0 is step mode, 1 is free-run.
- `display_out` output, 2*WIN+1 bits: tape window.
  - bit WIN is the head cell.
  - bit WIN+k is cell head-k.
  - bit WIN-k is cell head+k.
  - Cells outside 0..TAPE_LEN-1 read 0.
- `state_out` output, STATE_BITS: current state.
- `phase_out` output, 2 bits: 0 LOAD_TBL, 1 LOAD_TAPE, 2 RUN, 3 STOP.
- `step_count` output, CNT_BITS: steps executed, saturating at all-ones.
- `compute_done` output, 1 bit: HALT reached.
- `error` output, 1 bit: a head move left the tape.

## Operation

- Edge detect: `next_q` and `done_q` are registered copies. An event fires on the cycle where the input is 1 and its registered copy is 0.
- Table size is NUM_ENT = 2*(2^STATE_BITS-1). The entry index is {state, read_bit}, i.e. state*2+read_bit. HALT has no entries.
- LOAD_TBL:
  - Each `next` event writes `in_data` to entry[load_ptr] and increments load_ptr.
  - After entry NUM_ENT-1 is written, go to LOAD_TAPE and set load_ptr=0.
  - `done` is ignored in this phase.
- LOAD_TAPE:
  - Each `next` event writes in_data[0] to cell[load_ptr] and increments load_ptr.
  - `next` events are ignored once load_ptr=TAPE_LEN.
  - A `done` event goes to RUN with head=0 and state=0. Unwritten cells are 0.
  - If `done` and `next` events occur in the same cycle, `done` wins and no cell is written.
- RUN step:
  - Read b=cell[head] and look up e=entry[{state,b}].
  - Write cell[head]=e.write.
  - Set state=e.next_state and step_count+=1 (saturating).
  - Move the head per e.dir.
- Step trigger:
  - In step mode, a step runs on a `next` event.
  - In free-run, a step runs every cycle while mode=1, and `next` events are ignored.
  - A `mode` change takes effect on the following cycle.
- Halt: if e.next_state is all-ones, the step completes, then phase=STOP and compute_done=1.
- Boundary:
  - A move left at head=0, or right at head=TAPE_LEN-1, still writes the cell and updates state and count.
  - The head stays unchanged, phase=STOP and error=1.
  - If the step both halts and moves out of bounds, halt takes priority: compute_done=1 and error=0.
- STOP: all inputs are ignored until reset.
- Reset mid-operation returns to LOAD_TBL, with the table and tape cleared.

## Timing

- All outputs are registered.
- Reset values: display_out=0, state_out=0, phase_out=0, step_count=0, compute_done=0, error=0.
- An event sampled at edge N (`next` high, `next_q` low) takes effect at edge N+1. Outputs update after edge N+1.
- A held button gives exactly one event.
- Free-run rate: one step per clock.
- display_out, state_out, step_count and the flags reflect the post-step values in the same cycle. There is no extra pipeline stage.

## Test plan

All scenarios use default parameters. Entries are 4 bits, encoded {ns[1:0], dir, write}.

- **Halt after one step.** Load all 6 entries = 4'b1111, load tape {0}, then `done`, then one `next`. Required: cell0=1, head=1, display_out=11'b00001_0_00000, step_count=1, compute_done=1, error=0, phase_out=3.
- **Two-step program.**
  - Entries in order: 4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111. That is, state0/read0 writes 0, moves right, stays in state0; all other entries go to HALT writing 1, moving right.
  - Tape {1,0,1}... use tape {0,1}: state0 reads 0 at cell0 and moves right; state0/read1 at cell1 writes 1 and halts with head=2.
  - Required: step_count=2, compute_done=1, display_out=11'b00010_0_00000.
- **Free-run boundary.** Entries 4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b1111, 4'b1111, empty tape, then `done`, with mode=1. Required: after 64 cycles, error=1, compute_done=0, step_count=64, head=63, all cells=1.
- **Left-edge error.** All entries = 4'b0001, then one `next` step. Required: error=1, step_count=1, cell0=1, head=0, display_out=11'b00000_1_00000.
- **Button hold.** In step mode, hold `next` high for 10 cycles. Required: step_count increments by exactly 1. Also, `done` and `next` events in the same cycle during LOAD_TAPE: required phase_out=2 and the cell is not written.
- **Reset mid-run.** Drop reset_n mid free-run, asynchronously between edges. Required: all outputs are 0 immediately, and phase_out=0 after reset_n is released.

Source files
------------

// File: rtl/turing_machine_gen.sv
// turing_machine_gen: programmable single-tape binary Turing machine.
// The transition table is loaded first, then the initial tape. After that the
// machine runs one step per button press (step mode) or one step per clock
// (free-run). An 11-cell (by default) window of the tape follows the head.
module turing_machine_gen #(
  parameter int STATE_BITS = 2,
  parameter int TAPE_LEN   = 64,
  parameter int WIN        = 5,
  parameter int CNT_BITS   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [STATE_BITS+1:0] in_data,
  input  logic                  next,
  input  logic                  done,
  input  logic                  mode,
  output logic [2*WIN:0]        display_out,
  output logic [STATE_BITS-1:0] state_out,
  output logic [1:0]            phase_out,
  output logic [CNT_BITS-1:0]   step_count,
  output logic                  compute_done,
  output logic                  error
);

  localparam int EW      = STATE_BITS + 2;
  localparam int NUM_ENT = 2 * ((2 ** STATE_BITS) - 1);
  localparam int IDX_W   = STATE_BITS + 1;
  localparam int TBL_SZ  = 2 ** IDX_W;
  localparam int HEAD_W  = (TAPE_LEN > 1) ? $clog2(TAPE_LEN) : 1;
  localparam int PTR_MAX = (TAPE_LEN > NUM_ENT) ? TAPE_LEN : NUM_ENT;
  localparam int PTR_W   = $clog2(PTR_MAX + 1);
  localparam int DW      = 2 * WIN + 1;

  localparam logic [STATE_BITS-1:0] HALT_ST  = '1;
  localparam logic [PTR_W-1:0]      LAST_ENT = PTR_W'(NUM_ENT - 1);
  localparam logic [PTR_W-1:0]      TAPE_END = PTR_W'(TAPE_LEN);
  localparam logic [HEAD_W-1:0]     HEAD_MAX = HEAD_W'(TAPE_LEN - 1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX  = '1;

  typedef enum logic [1:0] {
    PH_LOAD_TBL  = 2'd0,
    PH_LOAD_TAPE = 2'd1,
    PH_RUN       = 2'd2,
    PH_STOP      = 2'd3
  } phase_e;

  // Registered state. Table entries beyond NUM_ENT-1 exist only so the
  // {state, bit} index covers the full address range; they stay zero.
  phase_e                phase_q, phase_d;
  logic [STATE_BITS-1:0] state_q, state_d;
  logic [HEAD_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic                  halt_q, halt_d;
  logic                  err_q, err_d;
  logic [TAPE_LEN-1:0]   tape_q, tape_d;
  logic [EW-1:0]         tbl_q [TBL_SZ];
  logic [EW-1:0]         tbl_d [TBL_SZ];
  logic [DW-1:0]         display_q, display_d;
  logic                  next_q, done_q, mode_q;
  logic                  next_ev_q, next_ev_d;
  logic                  done_ev_q, done_ev_d;

  // Combinational helpers
  logic                  rd_bit_s;
  logic [EW-1:0]         ent_s;
  logic [STATE_BITS-1:0] ent_ns_s;
  logic                  ent_dir_s;
  logic                  step_s;
  int                    cell_s;

  // Button edge detection; the event is registered so it acts one edge later.
  always_comb begin
    next_ev_d = next & ~next_q;
    done_ev_d = done & ~done_q;
  end

  // Phase sequencing, table/tape loading and the machine step itself.
  always_comb begin
    phase_d  = phase_q;
    state_d  = state_q;
    head_d   = head_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    halt_d   = halt_q;
    err_d    = err_q;
    tape_d   = tape_q;
    tbl_d    = tbl_q;
    rd_bit_s = tape_q[head_q];
    ent_s    = tbl_q[{state_q, rd_bit_s}];
    ent_ns_s = ent_s[EW-1:2];
    ent_dir_s = ent_s[1];
    step_s   = 1'b0;

    case (phase_q)
      PH_LOAD_TBL: begin
        if (next_ev_q) begin
          tbl_d[ptr_q[IDX_W-1:0]] = in_data;
          if (ptr_q == LAST_ENT) begin
            phase_d = PH_LOAD_TAPE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end

      PH_LOAD_TAPE: begin
        // done wins over a coincident next: nothing is written
        if (done_ev_q) begin
          phase_d = PH_RUN;
          head_d  = '0;
          state_d = '0;
          ptr_d   = '0;
        end else if (next_ev_q && (ptr_q < TAPE_END)) begin
          tape_d[ptr_q[HEAD_W-1:0]] = in_data[0];
          ptr_d = ptr_q + PTR_W'(1);
        end else begin
          ptr_d = ptr_q;
        end
      end

      PH_RUN: begin
        // mode_q is one cycle behind mode, so a mode change lands next cycle
        step_s = mode_q ? 1'b1 : next_ev_q;
        if (step_s) begin
          tape_d[head_q] = ent_s[0];
          state_d        = ent_ns_s;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (ent_ns_s == HALT_ST) begin
            // halting outranks a simultaneous boundary violation
            phase_d = PH_STOP;
            halt_d  = 1'b1;
            if (ent_dir_s && (head_q != HEAD_MAX)) begin
              head_d = head_q + HEAD_W'(1);
            end else if (!ent_dir_s && (head_q != '0)) begin
              head_d = head_q - HEAD_W'(1);
            end else begin
              head_d = head_q;
            end
          end else if ((ent_dir_s && (head_q == HEAD_MAX)) ||
                       (!ent_dir_s && (head_q == '0))) begin
            phase_d = PH_STOP;
            err_d   = 1'b1;
          end else if (ent_dir_s) begin
            head_d = head_q + HEAD_W'(1);
          end else begin
            head_d = head_q - HEAD_W'(1);
          end
        end else begin
          head_d = head_q;
        end
      end

      PH_STOP: begin
        phase_d = PH_STOP;
      end

      default: begin
        phase_d = phase_q;
      end
    endcase
  end

  // Tape window around the post-step head: bit WIN+k shows cell head-k.
  always_comb begin
    display_d = '0;
    cell_s    = 0;
    for (int i = 0; i < DW; i++) begin
      cell_s = int'(head_d) + WIN - i;
      if ((cell_s >= 0) && (cell_s < TAPE_LEN)) begin
        display_d[i] = tape_d[cell_s[HEAD_W-1:0]];
      end else begin
        display_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset clears phase, counters, flags, table and tape.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= PH_LOAD_TBL;
      state_q   <= '0;
      head_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      tape_q    <= '0;
      display_q <= '0;
      next_q    <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      next_ev_q <= 1'b0;
      done_ev_q <= 1'b0;
      for (int i = 0; i < TBL_SZ; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      phase_q   <= phase_d;
      state_q   <= state_d;
      head_q    <= head_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
      tape_q    <= tape_d;
      display_q <= display_d;
      next_q    <= next;
      done_q    <= done;
      mode_q    <= mode;
      next_ev_q <= next_ev_d;
      done_ev_q <= done_ev_d;
      tbl_q     <= tbl_d;
    end
  end

  assign display_out  = display_q;
  assign state_out    = state_q;
  assign phase_out    = phase_q;
  assign step_count   = cnt_q;
  assign compute_done = halt_q;
  assign error        = err_q;

endmodule

// File: tb/tb_turing_machine_gen.sv
// Scoreboard bench for turing_machine_gen: stimulus pushes expected output
// snapshots; a monitor pops each one when the DUT reaches the expected phase
// and step count (or after a fixed number of cycles) and compares.
module tb_turing_machine_gen;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_data = 4'd0;
  logic        next    = 1'b0;
  logic        done    = 1'b0;
  logic        mode    = 1'b0;
  logic [10:0] display_out;
  logic [1:0]  state_out;
  logic [1:0]  phase_out;
  logic [15:0] step_count;
  logic        compute_done;
  logic        error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ph;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        cd;
    logic        er;
    logic [10:0] disp;
    int          delay;   // 0: wait for phase+count match, N: compare at Nth sample
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  turing_machine_gen dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .next         (next),
    .done         (done),
    .mode         (mode),
    .display_out  (display_out),
    .state_out    (state_out),
    .phase_out    (phase_out),
    .step_count   (step_count),
    .compute_done (compute_done),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic expect_out(input string nm, input logic [1:0] ph, input logic [1:0] st,
                            input logic [15:0] cnt, input logic cd, input logic er,
                            input logic [10:0] disp, input int dly);
    exp_t e;
    e.ph = ph; e.st = st; e.cnt = cnt; e.cd = cd; e.er = er; e.disp = disp; e.delay = dly;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] v);
    in_data = v;
    next = 1'b1;
    ticks(2);
    next = 1'b0;
    ticks(2);
  endtask

  task automatic press_done();
    done = 1'b1;
    ticks(2);
    done = 1'b0;
    ticks(2);
  endtask

  task automatic press_both(input logic [3:0] v);
    in_data = v;
    next = 1'b1;
    done = 1'b1;
    ticks(2);
    next = 1'b0;
    done = 1'b0;
    ticks(2);
  endtask

  task automatic load_tbl(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
    press(a); press(b); press(c); press(d); press(e); press(f);
  endtask

  task automatic drain();
    while (exp_q.size() != 0) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    next = 1'b0;
    done = 1'b0;
    mode = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: pops expected snapshots and compares them against the DUT.
  initial begin : monitor
    exp_t  e;
    string nm;
    int    waited;
    bit    hit;
    bit    tmo;
    waited = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        nm = name_q[0];
        waited++;
        if (e.delay > 0) begin
          hit = (waited >= e.delay);
          tmo = 1'b0;
        end else begin
          hit = (phase_out === e.ph) && (step_count === e.cnt);
          tmo = !hit && (waited >= 400);
        end
        if (hit || tmo) begin
          checks++;
          if (tmo || phase_out !== e.ph || state_out !== e.st || step_count !== e.cnt ||
              compute_done !== e.cd || error !== e.er || display_out !== e.disp) begin
            errors++;
            $display("FAIL %s%s: got ph=%0d st=%0d cnt=%0d cd=%b er=%b disp=%b, want ph=%0d st=%0d cnt=%0d cd=%b er=%b disp=%b",
                     nm, tmo ? " (timeout)" : "", phase_out, state_out, step_count,
                     compute_done, error, display_out, e.ph, e.st, e.cnt, e.cd, e.er, e.disp);
          end
          void'(exp_q.pop_front());
          void'(name_q.pop_front());
          waited = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    expect_out("reset_state", 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_00000, 1);
    ticks(2);
    reset_n = 1'b1;
    tick();
    drain();

    // Halt after one step
    load_tbl(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    expect_out("tbl_loaded", 2'd1, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_00000, 0);
    drain();
    press(4'b0000);
    press_done();
    expect_out("run_entered", 2'd2, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_00000, 0);
    drain();
    press(4'b0000);
    expect_out("halt_one_step", 2'd3, 2'd3, 16'd1, 1'b1, 1'b0, 11'b00001_0_00000, 0);
    drain();
    checks++;
    if (display_out !== 11'b00001_0_00000 || compute_done !== 1'b1) begin
      errors++;
      $display("FAIL halt_direct: disp=%b cd=%b", display_out, compute_done);
    end

    // Two-step program, tape {0,1}
    do_reset();
    load_tbl(4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    press(4'b0000);
    press(4'b0001);
    press_done();
    expect_out("two_step_start", 2'd2, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_10000, 0);
    drain();
    press(4'b0000);
    expect_out("two_step_first", 2'd2, 2'd0, 16'd1, 1'b0, 1'b0, 11'b00000_1_00000, 0);
    drain();
    press(4'b0000);
    expect_out("two_step_halt", 2'd3, 2'd3, 16'd2, 1'b1, 1'b0, 11'b00001_0_00000, 0);
    drain();
    checks++;
    if (step_count !== 16'd2) begin
      errors++;
      $display("FAIL two_step_direct: cnt=%0d", step_count);
    end

    // Free-run to the right edge of an empty tape
    do_reset();
    load_tbl(4'b0111, 4'b0111, 4'b0011, 4'b0011, 4'b1111, 4'b1111);
    mode = 1'b1;
    press_done();
    expect_out("freerun_boundary", 2'd3, 2'd0, 16'd64, 1'b0, 1'b1, 11'b11111_1_00000, 0);
    drain();
    checks++;
    if (error !== 1'b1 || compute_done !== 1'b0) begin
      errors++;
      $display("FAIL freerun_direct: er=%b cd=%b", error, compute_done);
    end
    expect_out("stop_ignores_inputs", 2'd3, 2'd0, 16'd64, 1'b0, 1'b1, 11'b11111_1_00000, 8);
    press(4'b1111);
    press_done();
    drain();

    // Left-edge error on the first step
    do_reset();
    load_tbl(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    press_done();
    press(4'b0000);
    expect_out("left_edge", 2'd2 + 2'd1, 2'd0, 16'd1, 1'b0, 1'b1, 11'b00000_1_00000, 0);
    drain();
    checks++;
    if (display_out !== 11'b00000_1_00000 || step_count !== 16'd1) begin
      errors++;
      $display("FAIL left_edge_direct: disp=%b cnt=%0d", display_out, step_count);
    end

    // done beats a coincident next; held button steps once; short free-run burst
    do_reset();
    load_tbl(4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011);
    press(4'b0001);
    press_both(4'b0001);
    expect_out("done_wins", 2'd2, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_1_00000, 0);
    drain();
    expect_out("button_hold", 2'd2, 2'd0, 16'd1, 1'b0, 1'b0, 11'b00001_0_00000, 14);
    next = 1'b1;
    ticks(10);
    next = 1'b0;
    drain();
    expect_out("mode_burst", 2'd2, 2'd0, 16'd4, 1'b0, 1'b0, 11'b01111_0_00000, 6);
    mode = 1'b1;
    ticks(3);
    mode = 1'b0;
    drain();
    checks++;
    if (phase_out !== 2'd2) begin
      errors++;
      $display("FAIL mode_burst_direct: ph=%0d", phase_out);
    end

    // Asynchronous reset in the middle of free-run
    mode = 1'b1;
    ticks(5);
    #2;
    reset_n = 1'b0;
    mode = 1'b0;
    expect_out("async_reset", 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_00000, 1);
    #1;
    checks++;
    if (phase_out !== 2'd0 || state_out !== 2'd0 || step_count !== 16'd0 ||
        compute_done !== 1'b0 || error !== 1'b0 || display_out !== 11'd0) begin
      errors++;
      $display("FAIL async_reset_direct: ph=%0d st=%0d cnt=%0d cd=%b er=%b disp=%b",
               phase_out, state_out, step_count, compute_done, error, display_out);
    end
    ticks(2);
    reset_n = 1'b1;
    expect_out("after_release", 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 11'b00000_0_00000, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
